// File: rtl/load_store_unit.sv
// Load/store unit: data-memory access stage between the ALU and the
// writeback result mux. It decodes size/sign, checks alignment, steers
// store bytes onto lanes, runs one req/ack bus transfer with a timeout,
// and returns sign/zero-extended load data with a one-cycle ready pulse.
module load_store_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ls_valid,
  input  logic        ls_is_store,
  input  logic [2:0]  ls_funct3,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_ready,
  output logic [31:0] ls_rdata,
  output logic        ls_misaligned,
  output logic        ls_fault,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last counter value before the bus access is declared dead.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;

  // Operation latched when the bus access starts; held for the whole BUS state.
  logic [2:0]  f3_p0;
  logic [1:0]  off_p0;
  logic        we_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;
  logic [3:0]  wstrb_p0;

  logic        fault_q;
  logic        mis_q;
  logic [31:0] rdata_q;

  logic        f3_legal;
  logic        addr_mis;
  logic        take_bus;
  logic        set_fault;
  logic        set_mis;
  logic        capture;
  logic        cnt_inc;

  // Select the addressed byte/half from the read word and extend it.
  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        res;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = 32'(b);
      3'b001:  res = 32'(h);
      3'b100:  res = {24'd0, b};
      3'b101:  res = {16'd0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replicate the store operand across every lane it could land on.
  function automatic logic [31:0] store_lanes(input logic [2:0]  f3,
                                              input logic [31:0] wd);
    logic [31:0] res;
    case (f3[1:0])
      2'b00:   res = {4{wd[7:0]}};
      2'b01:   res = {2{wd[15:0]}};
      default: res = wd;
    endcase
    return res;
  endfunction

  // Byte strobes for a store; loads never assert strobes.
  function automatic logic [3:0] store_strobe(input logic       st,
                                              input logic [2:0] f3,
                                              input logic [1:0] off);
    logic [3:0] res;
    if (!st) begin
      res = 4'b0000;
    end else begin
      case (f3[1:0])
        2'b00:   res = 4'b0001 << off;
        2'b01:   res = off[1] ? 4'b1100 : 4'b0011;
        default: res = 4'b1111;
      endcase
    end
    return res;
  endfunction

  // Decode legality and alignment of the presented operation.
  always_comb begin
    f3_legal = 1'b0;
    case (ls_funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = !ls_is_store;
      default:                f3_legal = 1'b0;
    endcase
    addr_mis = ((ls_funct3[1:0] == 2'b01) && ls_addr[0]) ||
               ((ls_funct3[1:0] == 2'b10) && (ls_addr[1:0] != 2'b00));
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    take_bus  = 1'b0;
    set_fault = 1'b0;
    set_mis   = 1'b0;
    capture   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (ls_valid) begin
          if (!f3_legal) begin
            set_fault = 1'b1;
            state_nxt = DONE;
          end else if (addr_mis) begin
            set_mis   = 1'b1;
            state_nxt = DONE;
          end else begin
            take_bus  = 1'b1;
            state_nxt = BUS;
          end
        end
      end
      BUS: begin
        if (mem_ack) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          set_fault = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_inc   = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, timeout counter, result flags and load result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      fault_q <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state <= state_nxt;
      if (take_bus) begin
        cnt <= 8'd0;
      end else if (cnt_inc) begin
        cnt <= cnt + 8'd1;
      end
      if (state == DONE) begin
        fault_q <= 1'b0;
        mis_q   <= 1'b0;
      end else begin
        if (set_fault) fault_q <= 1'b1;
        if (set_mis)   mis_q   <= 1'b1;
      end
      if ((state != DONE) && (state_nxt == DONE)) begin
        rdata_q <= (capture && !we_p0) ? load_extend(f3_p0, off_p0, mem_rdata) : 32'd0;
      end
    end
  end

  // Latch the operation as the bus access begins (pipeline stage p0).
  always_ff @(posedge clk) begin
    if (take_bus) begin
      f3_p0    <= ls_funct3;
      off_p0   <= ls_addr[1:0];
      we_p0    <= ls_is_store;
      addr_p0  <= {ls_addr[31:2], 2'b00};
      wdata_p0 <= store_lanes(ls_funct3, ls_wdata);
      wstrb_p0 <= store_strobe(ls_is_store, ls_funct3, ls_addr[1:0]);
    end
  end

  assign mem_req       = (state == BUS);
  assign mem_we        = mem_req & we_p0;
  assign mem_addr      = mem_req ? addr_p0  : 32'd0;
  assign mem_wdata     = mem_req ? wdata_p0 : 32'd0;
  assign mem_wstrb     = mem_req ? wstrb_p0 : 4'd0;
  assign ls_ready      = (state == DONE);
  assign ls_rdata      = rdata_q;
  assign ls_misaligned = mis_q;
  assign ls_fault      = fault_q;
  assign stall         = ls_valid & ~ls_ready;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the driver pushes expected
// responses and bus transfers; a bus responder and a result monitor
// pop and compare independently.
module tb_load_store_unit;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls_valid;
  logic        ls_is_store;
  logic [2:0]  ls_funct3;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_ready;
  logic [31:0] ls_rdata;
  logic        ls_misaligned;
  logic        ls_fault;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        ack_r = 1'b0;
  logic        stray_ack = 1'b0;

  assign mem_ack = ack_r | stray_ack;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ls_valid(ls_valid), .ls_is_store(ls_is_store), .ls_funct3(ls_funct3),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ready(ls_ready), .ls_rdata(ls_rdata),
    .ls_misaligned(ls_misaligned), .ls_fault(ls_fault), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        flt;
    int          lat;
    int          start;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          waits;
    logic [31:0] rdata;
    int          req_cycles;
  } bus_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  int    checks = 0;
  int    errors = 0;
  int    req_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Bus responder: checks the request on its first cycle, acks after the
  // programmed number of wait cycles and checks how long mem_req stayed high.
  initial begin
    bus_t cur;
    int   req_cnt;
    req_cnt = 0;
    cur = '{we: 1'b0, addr: 32'd0, wdata: 32'd0, wstrb: 4'd0, waits: -1, rdata: 32'd0, req_cycles: 0};
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (req_cnt == 0) begin
          if (bus_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_mem_req: got mem_req=1 addr 0x%08h expected no request", mem_addr);
            cur = '{we: 1'b0, addr: 32'd0, wdata: 32'd0, wstrb: 4'd0, waits: -1, rdata: 32'd0, req_cycles: 0};
          end else begin
            cur = bus_q.pop_front();
            check("mem_we", 32'(mem_we), 32'(cur.we));
            check("mem_addr", mem_addr, cur.addr);
            check("mem_wstrb", 32'(mem_wstrb), 32'(cur.wstrb));
            if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
          end
        end
        req_total++;
        mem_rdata = cur.rdata;
        ack_r     = (req_cnt == cur.waits);
        req_cnt++;
      end else begin
        if (req_cnt > 0) begin
          check("mem_req_cycles", 32'(req_cnt), 32'(cur.req_cycles));
          req_cnt = 0;
        end
        ack_r     = 1'b0;
        mem_rdata = 32'd0;
      end
    end
  end

  // Result monitor: every ls_ready pulse must match the oldest expected response.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (ls_ready) begin
        if (resp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ls_ready: got ls_ready=1 rdata 0x%08h expected no completion", ls_rdata);
        end else begin
          r = resp_q.pop_front();
          check("ls_rdata", ls_rdata, r.rdata);
          check("ls_misaligned", 32'(ls_misaligned), 32'(r.mis));
          check("ls_fault", 32'(ls_fault), 32'(r.flt));
          check("latency", 32'(cyc - r.start), 32'(r.lat));
        end
      end
    end
  end

  // Issue one op, queue its expectations, hold it until ls_ready.
  // waits < 0 means the responder never acks.
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input bit uses_bus, input int waits,
                        input logic [31:0] bus_rdata, input logic [31:0] exp_wdata,
                        input logic [3:0] exp_strb, input logic [31:0] exp_rdata,
                        input logic exp_mis, input logic exp_flt, input int exp_lat);
    resp_t r;
    bus_t  b;
    int    sc;
    int    req_before;
    bit    seen;
    @(negedge clk);
    if (uses_bus) begin
      b.we = st;
      b.addr = {addr[31:2], 2'b00};
      b.wdata = exp_wdata;
      b.wstrb = exp_strb;
      b.waits = waits;
      b.rdata = bus_rdata;
      b.req_cycles = (waits < 0) ? TO : waits + 1;
      bus_q.push_back(b);
    end
    r.rdata = exp_rdata;
    r.mis = exp_mis;
    r.flt = exp_flt;
    r.lat = exp_lat;
    r.start = cyc;
    resp_q.push_back(r);
    req_before  = req_total;
    ls_is_store = st;
    ls_funct3   = f3;
    ls_addr     = addr;
    ls_wdata    = wd;
    ls_valid    = 1'b1;
    #1;
    sc = 0;
    seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (stall) sc++;
      if (ls_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got no ls_ready in 200 cycles expected ls_ready");
    end
    ls_valid = 1'b0;
    check("stall_cycles", 32'(sc), 32'(exp_lat));
    if (!uses_bus) check("no_bus_activity", 32'(req_total - req_before), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    rst = 1'b1;
    ls_valid = 1'b0;
    ls_is_store = 1'b0;
    ls_funct3 = 3'd0;
    ls_addr = 32'd0;
    ls_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ls_ready", 32'(ls_ready), 32'd0);
    check("rst_ls_rdata", ls_rdata, 32'd0);
    check("rst_flags", {30'd0, ls_misaligned, ls_fault}, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_mem_ctl", {30'd0, mem_req, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    rst = 1'b0;

    // LW, zero-wait ack
    run_op(1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 0, 32'hDEADBEEF, 32'h0, 4'b0000,
           32'hDEADBEEF, 1'b0, 1'b0, 2);
    @(negedge clk);
    check("ls_rdata_hold", ls_rdata, 32'hDEADBEEF);

    // Load extension
    run_op(1'b0, 3'b000, 32'h103, 32'h0, 1'b1, 1, 32'h80123456, 32'h0, 4'b0000,
           32'hFFFFFF80, 1'b0, 1'b0, 3);
    run_op(1'b0, 3'b100, 32'h103, 32'h0, 1'b1, 0, 32'h80123456, 32'h0, 4'b0000,
           32'h00000080, 1'b0, 1'b0, 2);
    run_op(1'b0, 3'b001, 32'h102, 32'h0, 1'b1, 2, 32'h8001FFFF, 32'h0, 4'b0000,
           32'hFFFF8001, 1'b0, 1'b0, 4);
    run_op(1'b0, 3'b101, 32'h100, 32'h0, 1'b1, 0, 32'h0000F00F, 32'h0, 4'b0000,
           32'h0000F00F, 1'b0, 1'b0, 2);

    // Store steering; read bus returns junk that must not reach ls_rdata
    run_op(1'b1, 3'b000, 32'h101, 32'h000000AB, 1'b1, 0, 32'h55555555, 32'hABABABAB, 4'b0010,
           32'h0, 1'b0, 1'b0, 2);
    run_op(1'b1, 3'b001, 32'h102, 32'h00001234, 1'b1, 1, 32'h55555555, 32'h12341234, 4'b1100,
           32'h0, 1'b0, 1'b0, 3);
    run_op(1'b1, 3'b010, 32'h104, 32'hCAFEF00D, 1'b1, 0, 32'h55555555, 32'hCAFEF00D, 4'b1111,
           32'h0, 1'b0, 1'b0, 2);

    // Faults with no bus activity
    run_op(1'b0, 3'b010, 32'h102, 32'h0, 1'b0, 0, 32'h0, 32'h0, 4'b0000,
           32'h0, 1'b1, 1'b0, 1);
    run_op(1'b0, 3'b001, 32'h101, 32'h0, 1'b0, 0, 32'h0, 32'h0, 4'b0000,
           32'h0, 1'b1, 1'b0, 1);
    run_op(1'b0, 3'b011, 32'h100, 32'h0, 1'b0, 0, 32'h0, 32'h0, 4'b0000,
           32'h0, 1'b0, 1'b1, 1);
    run_op(1'b1, 3'b101, 32'h100, 32'h1234, 1'b0, 0, 32'h0, 32'h0, 4'b0000,
           32'h0, 1'b0, 1'b1, 1);

    // Bus timeout, then ack landing on the final allowed cycle
    run_op(1'b0, 3'b010, 32'h108, 32'h0, 1'b1, -1, 32'h77777777, 32'h0, 4'b0000,
           32'h0, 1'b0, 1'b1, TO + 1);
    run_op(1'b0, 3'b010, 32'h10C, 32'h0, 1'b1, TO - 1, 32'h13579BDF, 32'h0, 4'b0000,
           32'h13579BDF, 1'b0, 1'b0, TO + 1);

    // Reset in the second wait cycle of an LW, then a late ack in IDLE
    @(negedge clk);
    bus_q.push_back('{we: 1'b0, addr: 32'h110, wdata: 32'h0, wstrb: 4'b0000,
                      waits: -1, rdata: 32'h99999999, req_cycles: 2});
    ls_is_store = 1'b0;
    ls_funct3   = 3'b010;
    ls_addr     = 32'h110;
    ls_valid    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b1;
    ls_valid = 1'b0;
    @(negedge clk);
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_stall", 32'(stall), 32'd0);
    check("abort_ls_ready", 32'(ls_ready), 32'd0);
    check("abort_ls_rdata", ls_rdata, 32'd0);
    check("abort_flags", {30'd0, ls_misaligned, ls_fault}, 32'd0);
    check("abort_mem_bus", {mem_we, mem_wstrb, 27'd0} | mem_addr | mem_wdata, 32'd0);
    rst       = 1'b0;
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    check("late_ack_ignored", {30'd0, ls_ready, mem_req}, 32'd0);

    run_op(1'b0, 3'b010, 32'h110, 32'h0, 1'b1, 0, 32'h0BADCAFE, 32'h0, 4'b0000,
           32'h0BADCAFE, 1'b0, 1'b0, 2);

    repeat (3) @(negedge clk);
    check("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory access stage downstream of the ALU and upstream of the writeback result mux.
- Takes the ALU-computed effective address and the rs2 store data for load/store instructions.
- Performs byte, half and word accesses over a req/ack data bus with alignment checks, byte-lane steering and sign/zero extension.
- Returns the load value to the data-memory input of the writeback mux and stalls the core until the access completes.

Parameters:
- TIMEOUT, 64, max BUS-state cycles awaiting mem_ack before a bus fault (legal range 2..255).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- ls_valid  input  1  core presents a memory op; held with all ls_* inputs stable until ls_ready
- ls_is_store  input  1  1=store, 0=load
- ls_funct3  input  3  RISC-V funct3 (size/sign)
- ls_addr  input  32  effective byte address (ALU result)
- ls_wdata  input  32  store data (rs2)
- ls_ready  output  1  one-cycle pulse: op complete
- ls_rdata  output  32  extended load data; 0 for stores and faults
- ls_misaligned  output  1  alignment fault, valid with ls_ready
- ls_fault  output  1  illegal funct3 or bus timeout, valid with ls_ready
- stall  output  1  ls_valid & !ls_ready
- mem_req  output  1  bus request
- mem_we  output  1  write enable
- mem_addr  output  32  word-aligned address ({ls_addr[31:2],2'b00})
- mem_wdata  output  32  lane-replicated store data
- mem_wstrb  output  4  byte strobes; 0 for loads
- mem_ack  input  1  bus completion
- mem_rdata  input  32  read word, valid with mem_ack

Behaviour:
- Reset: state IDLE, timeout counter 0, every output 0; registered ls_rdata cleared.
- Reset mid-transaction: mem_req low after the reset edge; a late mem_ack is ignored in IDLE.
- IDLE:
  - On ls_valid, decode ls_funct3.
  - Legal funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU. BU/HU with ls_is_store=1 are illegal.
  - Illegal funct3: set ls_fault, go to DONE, no bus activity.
  - Misaligned (H with addr[0]=1, W with addr[1:0]!=0): set ls_misaligned, go to DONE, no bus activity.
  - Otherwise latch addr, lanes, strobe and op, clear the counter, go to BUS.
- BUS:
  - mem_req=1, with mem_we/mem_addr/mem_wdata/mem_wstrb held constant.
  - mem_ack: capture and extend rdata, go to DONE.
  - No ack and counter==TIMEOUT-1: set ls_fault, go to DONE.
  - Otherwise the counter increments. mem_req is high for at most TIMEOUT cycles; ack on the final cycle wins over timeout.
- DONE: ls_ready=1 for exactly one cycle, mem_req=0, then go to IDLE. Flags clear when leaving DONE. ls_rdata holds until the next DONE.
- Latency: ls_ready two cycles after ls_valid with a zero-wait ack (IDLE, BUS, DONE); one cycle for fault ops (IDLE, DONE).
- ls_valid still high in the cycle after ls_ready starts a new op.
- Changes on ls_* inputs after latching are ignored.
- Store lanes:
  - SB: wdata={4{ls_wdata[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{ls_wdata[15:0]}}, wstrb=addr[1]?1100:0011.
  - SW: wdata=ls_wdata, wstrb=1111.
- Loads:
  - Byte lane selected by addr[1:0], half lane by addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes the word unchanged.
- ls_rdata=0 for stores and for any faulting op.

Test Plan:
- LW addr 0x100, ack in first BUS cycle, rdata 0xDEADBEEF -> mem_addr 0x100, wstrb 0000, ls_ready 2 cycles after ls_valid, ls_rdata 0xDEADBEEF, stall high 2 cycles.
- Load extension:
  - LB 0x103, rdata 0x80123456 -> 0xFFFFFF80.
  - LBU same -> 0x00000080.
  - LH 0x102, rdata 0x8001FFFF -> 0xFFFF8001.
  - LHU 0x100, rdata 0x0000F00F -> 0x0000F00F.
- Store steering:
  - SB 0x101, wdata 0x000000AB -> mem_we 1, mem_addr 0x100, mem_wdata 0xABABABAB, wstrb 0010.
  - SH 0x102, wdata 0x00001234 -> mem_wdata 0x12341234, wstrb 1100, ls_rdata 0.
- Faults without bus activity:
  - LW 0x102 -> ls_misaligned=1 with ls_ready 1 cycle after ls_valid, mem_req never high.
  - funct3 011 -> ls_fault=1, mem_req never high.
- TIMEOUT=8, ack withheld -> mem_req high exactly 8 cycles, then ls_ready with ls_fault=1, ls_rdata 0. Repeat with ack on the 8th cycle -> no fault, data captured.
- LW with 3 wait cycles, rst pulsed in the 2nd wait cycle -> mem_req 0 and stall 0 after the edge, all outputs 0, ack in the following cycle produces no ls_ready. Next LW completes normally.
